// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset multi-cycle control sequencer:
// opcodes, FSM states, instruction classes, ALU codes and mux selects.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_ILLEGAL
    } insn_class_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Only word loads/stores and BEQ/BNE are implemented in this subset.
    function automatic insn_class_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
        insn_class_t cls;
        case (opcode)
            OP_R:      cls = CLS_R;
            OP_I:      cls = CLS_I;
            OP_LOAD:   cls = (funct3 == 3'b010) ? CLS_LOAD : CLS_ILLEGAL;
            OP_STORE:  cls = (funct3 == 3'b010) ? CLS_STORE : CLS_ILLEGAL;
            OP_BRANCH: cls = (funct3[2:1] == 2'b00) ? CLS_BRANCH : CLS_ILLEGAL;
            OP_JAL:    cls = CLS_JAL;
            default:   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from instruction class and funct fields.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  insn_class_t cls,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    output logic [2:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (cls)
            CLS_R, CLS_I: begin
                // funct7[5] selects SUB only for register ops; on ADDI it is immediate data.
                case (funct3)
                    3'b000:  alu_control = (cls == CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    3'b100:  alu_control = ALU_XOR;
                    3'b010:  alu_control = ALU_SLT;
                    3'b001:  alu_control = ALU_SLL;
                    3'b101:  alu_control = ALU_SRL;
                    default: alu_control = ALU_ADD;
                endcase
            end
            CLS_BRANCH: alu_control = ALU_SUB;
            default:    alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-timeout
// and illegal-instruction traps plus a wrapping retired-instruction counter.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      insn,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_b,
    output logic [2:0]       alu_control,
    output logic [2:0]       state,
    output logic             retired,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             illegal_insn,
    output logic             bus_error
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [6:0]       opcode_q;
    logic [2:0]       funct3_q;
    logic             funct7_b5_q;
    logic [7:0]       wait_cnt_q;
    logic [CNT_W-1:0] retired_cnt_q;
    logic             illegal_q, bus_err_q;
    insn_class_t      cls;
    logic [2:0]       alu_dec;
    logic             taken, timed_out, mem_wait_state;
    logic             unused_insn_bits;

    assign unused_insn_bits = ^{insn[31], insn[29:15], insn[11:7]};

    assign cls            = classify(opcode_q, funct3_q);
    assign taken          = funct3_q[0] ? ~zero : zero;
    assign mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEM);
    // A ready arriving in the limit cycle still completes the access.
    assign timed_out      = mem_wait_state && !mem_ready && (wait_cnt_q == WAIT_LIMIT);

    alu_decoder u_alu_decoder (
        .cls         (cls),
        .funct3      (funct3_q),
        .funct7_b5   (funct7_b5_q),
        .alu_control (alu_dec)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timed_out) state_d = S_TRAP;
            end
            S_DECODE: state_d = (cls == CLS_ILLEGAL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (cls)
                    CLS_R, CLS_I:          state_d = S_WB;
                    CLS_LOAD, CLS_STORE:   state_d = S_MEM;
                    CLS_BRANCH, CLS_JAL:   state_d = S_FETCH;
                    default:               state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (mem_ready)      state_d = (cls == CLS_LOAD) ? S_WB : S_FETCH;
                else if (timed_out) state_d = S_TRAP;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_TRAP;
        endcase
    end

    // Reset holds the FSM in FETCH, so the request is masked by reset itself.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_PLUS4;
        reg_write   = 1'b0;
        wb_sel      = WB_ALU;
        alu_src_b   = 1'b0;
        alu_control = ALU_ADD;
        retired     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req  = reset;
                ir_write = reset & mem_ready;
            end
            S_EXEC: begin
                alu_control = alu_dec;
                alu_src_b   = !(cls == CLS_R || cls == CLS_BRANCH);
                if (cls == CLS_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = taken ? PC_BRANCH : PC_PLUS4;
                    retired  = 1'b1;
                end else if (cls == CLS_JAL) begin
                    pc_write  = 1'b1;
                    pc_src    = PC_JAL;
                    reg_write = 1'b1;
                    wb_sel    = WB_PC4;
                    retired   = 1'b1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls == CLS_STORE);
                if (mem_ready && cls == CLS_STORE) begin
                    pc_write = 1'b1;
                    retired  = 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (cls == CLS_LOAD) ? WB_MEM : WB_ALU;
                pc_write  = 1'b1;
                retired   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_FETCH;
            opcode_q      <= '0;
            funct3_q      <= '0;
            funct7_b5_q   <= 1'b0;
            wait_cnt_q    <= '0;
            retired_cnt_q <= '0;
            illegal_q     <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && mem_ready) begin
                opcode_q    <= insn[6:0];
                funct3_q    <= insn[14:12];
                funct7_b5_q <= insn[30];
            end
            // Every state change clears the wait count, covering entry to FETCH and MEM.
            if (state_d != state_q)
                wait_cnt_q <= '0;
            else if (mem_wait_state && !mem_ready && wait_cnt_q != WAIT_LIMIT)
                wait_cnt_q <= wait_cnt_q + 8'd1;
            if (retired)
                retired_cnt_q <= retired_cnt_q + CNT_W'(1);
            if (state_q == S_DECODE && cls == CLS_ILLEGAL)
                illegal_q <= 1'b1;
            if (timed_out)
                bus_err_q <= 1'b1;
        end
    end

    assign state        = state_q;
    assign retired_cnt  = retired_cnt_q;
    assign illegal_insn = illegal_q;
    assign bus_error    = bus_err_q;

endmodule
